gpio_input_capture: RTL and testbench
=====================================

// Module: gpio_input_capture
// PURPOSE
//  Board-input counterpart of the seven-segment output path. Samples the raw
//  slide switches and push buttons, then synchronises and debounces them.
//  On each debounced button press it captures one 32-bit word into a FIFO.
//  The RV32I core side drains the FIFO with a read strobe. Runs on the board
//  clock, alongside the writeback buffer and display driver.
// PARAMETERS
//  DEPTH      16       FIFO entries; power of two, 2..16
//  DB_CYCLES  1000000  consecutive stable clocks required to accept a new button level (>=2)
// PORTS
//  clk             in   1   board clock; all state changes on its rising edge
//  n_rst           in   1   asynchronous, active-low reset
//  SW              in   16  raw slide switches; asynchronous to clk
//  BTN             in   5   raw push buttons; asynchronous to clk; active high
//  read_req        in   1   pop strobe from core side, one pop per high cycle
//  read_data       out  32  FIFO head word, meaningful only while data_valid=1
//  data_valid      out  1   FIFO not empty
//  buffer_occ      out  5   number of entries held, 0..DEPTH
//  overflow        out  1   sticky flag: a capture was dropped because the FIFO was full
//  clear_overflow  in   1   synchronous clear of overflow
// BEHAVIOUR
//  Reset (n_rst=0, async): all outputs and state go to 0.
//   - read_data=0, data_valid=0, buffer_occ=0, overflow=0.
//   - Pointers, synchroniser flops, debounce counters and debounced levels are all 0.
//  Synchroniser: SW and BTN each pass through a 2-flop chain giving sw_s and btn_s.
//  Debounce: each button has its own counter, sized $clog2(DB_CYCLES+1) bits.
//   - btn_s[i]==db[i]: counter is cleared.
//   - btn_s[i]!=db[i]: counter increments.
//   - When the counter reaches DB_CYCLES-1 while still differing, db[i] toggles
//     and the counter is cleared.
//   - Net effect: db[i] changes after DB_CYCLES consecutive differing cycles.
//     A glitch shorter than that is ignored.
//  Capture: press[i] = db[i] & ~db_q[i], where db_q is db delayed by one cycle.
//   - Any press bit set gives a push request with the word
//     {11'b0, press[4:0], sw_s[15:0]}.
//   - Simultaneous presses produce ONE entry with several press bits set.
//   - Releases produce no entry.
//  Latency: raw BTN rises and is held stable at clock edge E.
//   - db rises at edge E+1+DB_CYCLES.
//   - The push occurs at edge E+2+DB_CYCLES.
//   - data_valid rises after edge E+2+DB_CYCLES (±1 edge depending on metastability).
//  FIFO: first-word-fall-through. read_data = mem[rd_ptr] whenever data_valid=1.
//   - Pop: read_req=1 with data_valid=1 advances rd_ptr at the clock edge.
//   - read_req while empty is ignored; no pointer change, no error.
//   - Push while occ<DEPTH: write at wr_ptr, advance wr_ptr.
//   - Push while occ==DEPTH and no pop: entry dropped, overflow<=1.
//   - Push + pop while full: both happen, occ stays DEPTH, no overflow.
//   - Push + read_req while empty: push accepted, pop ignored, occ becomes 1.
//   - Pointers wrap modulo DEPTH. buffer_occ is a registered count, not a pointer difference.
//  overflow: set by a dropped push, cleared by clear_overflow.
//   - If both happen in the same cycle, set wins.
//  Reset mid-operation: FIFO contents are discarded and debouncing restarts from 0.
//   - A button held through reset release is therefore reported as a new press.
// TESTING (DB_CYCLES=4, DEPTH=4)
//  1. Reset, SW=16'h00A5, hold BTN=5'b00001 for 20 clks
//     -> one entry 32'h0001_00A5, data_valid=1, buffer_occ=1.
//  2. BTN[0] glitch high for 3 clks
//     -> no entry; buffer_occ stays 0; db never changes.
//  3. Press BTN[2] and BTN[4] together with SW=16'hBEEF
//     -> single entry 32'h0014_BEEF.
//  4. Five presses with no reads -> buffer_occ=4, overflow=1.
//     - Four reads return the first four words in order, then data_valid=0.
//     - overflow stays 1 until clear_overflow is pulsed.
//  5. FIFO full and a press push coincides with read_req -> occ stays 4, overflow stays 0.
//     - Then assert read_req while empty -> occ stays 0, read_data unchanged.
//  6. Assert n_rst=0 asynchronously mid-debounce with two entries queued
//     -> all outputs 0 immediately.
//     - BTN held through release -> new entry after 2+DB_CYCLES clks.

Source files
------------

// File: rtl/gpio_input_capture.sv
// Board input capture: synchronises and debounces the switches and buttons. Each debounced
// button press queues {11'b0, press, switches} in a first-word-fall-through FIFO for the core.
module gpio_input_capture #(
    parameter int DEPTH     = 16,
    parameter int DB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [15:0] SW,
    input  logic [4:0]  BTN,
    input  logic        read_req,
    output logic [31:0] read_data,
    output logic        data_valid,
    output logic [4:0]  buffer_occ,
    output logic        overflow,
    input  logic        clear_overflow
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int PW = $clog2(DEPTH);

    logic [15:0]   sw_m, sw_s;
    logic [4:0]    btn_m, btn_s;
    logic [4:0]    db, db_q, press;
    logic [CW-1:0] db_cnt [5];

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    occ;
    logic          push, pop, full, push_ok, drop;
    logic [31:0]   push_word;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sw_m  <= '0;
            sw_s  <= '0;
            btn_m <= '0;
            btn_s <= '0;
        end else begin
            sw_m  <= SW;
            sw_s  <= sw_m;
            btn_m <= BTN;
            btn_s <= btn_m;
        end
    end

    // db[i] flips once btn_s[i] has disagreed with it for DB_CYCLES consecutive clocks
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            db   <= '0;
            db_q <= '0;
            for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
        end else begin
            db_q <= db;
            for (int i = 0; i < 5; i++) begin
                if (btn_s[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
                    db[i]     <= ~db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign press     = db & ~db_q;
    assign push      = |press;
    assign push_word = {11'b0, press, sw_s};

    assign data_valid = (occ != 5'd0);
    assign full       = (occ == 5'(DEPTH));
    assign pop        = read_req & data_valid;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign push_ok    = push & (~full | pop);
    assign drop       = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   occ <= occ + 5'd1;
                2'b01:   occ <= occ - 5'd1;
                default: occ <= occ;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

    // memory is not reset, so the head is masked until something has been written
    assign read_data  = data_valid ? mem[rd_ptr] : 32'd0;
    assign buffer_occ = occ;

endmodule

// File: tb/tb_gpio_input_capture.sv
// Directed bench for gpio_input_capture with DEPTH=4, DB_CYCLES=4: table of stimulus rows
// with hand-computed expectations, plus a hand-written async reset / latency sequence.
module tb_gpio_input_capture;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [15:0] sw;
    logic [4:0]  btn;
    logic        read_req;
    logic [31:0] read_data;
    logic        data_valid;
    logic [4:0]  buffer_occ;
    logic        overflow;
    logic        clear_overflow;

    int checks = 0;
    int errors = 0;

    gpio_input_capture #(.DEPTH(4), .DB_CYCLES(4)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .SW             (sw),
        .BTN            (btn),
        .read_req       (read_req),
        .read_data      (read_data),
        .data_valid     (data_valid),
        .buffer_occ     (buffer_occ),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sw;
        logic [4:0]  btn;
        logic        rd;
        logic        clr;
        int          n;
        logic [4:0]  occ;
        logic        valid;
        logic [31:0] data;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [15:0] s, input logic [4:0] b, input logic rd, input logic clr,
                       input int n, input logic [4:0] occ, input logic v, input logic [31:0] d,
                       input logic o);
        vec_t r;
        r.sw = s; r.btn = b; r.rd = rd; r.clr = clr; r.n = n;
        r.occ = occ; r.valid = v; r.data = d; r.ovf = o;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic press_release(input logic [15:0] s, input logic [4:0] occ_after,
                                 input logic [31:0] head, input logic o);
        add(s, 5'b00001, 1'b0, 1'b0, 8, occ_after, 1'b1, head, o);
        add(s, 5'b00000, 1'b0, 1'b0, 8, occ_after, 1'b1, head, o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        n_rst = 1'b0; sw = '0; btn = '0; read_req = 1'b0; clear_overflow = 1'b0;

        // basic press, release, read, glitch, simultaneous press
        add(16'h00A5, 5'b00000, 0, 0,  1, 5'd0, 0, 32'h0,         0);
        add(16'h00A5, 5'b00001, 0, 0, 20, 5'd1, 1, 32'h0001_00A5, 0);
        add(16'h00A5, 5'b00000, 0, 0, 10, 5'd1, 1, 32'h0001_00A5, 0);
        add(16'h00A5, 5'b00000, 1, 0,  1, 5'd0, 0, 32'h0,         0);
        add(16'h00A5, 5'b00001, 0, 0,  3, 5'd0, 0, 32'h0,         0);
        add(16'h00A5, 5'b00000, 0, 0, 10, 5'd0, 0, 32'h0,         0);
        add(16'hBEEF, 5'b10100, 0, 0, 12, 5'd1, 1, 32'h0014_BEEF, 0);
        add(16'hBEEF, 5'b00000, 0, 0, 10, 5'd1, 1, 32'h0014_BEEF, 0);
        add(16'hBEEF, 5'b00000, 1, 0,  1, 5'd0, 0, 32'h0,         0);
        // five presses into a four-entry FIFO
        for (int k = 1; k <= 5; k++)
            press_release(16'(k), (k > 4) ? 5'd4 : 5'(k), 32'h0001_0001, (k == 5));
        add(16'h0005, 5'b00000, 1, 0,  1, 5'd3, 1, 32'h0001_0002, 1);
        add(16'h0005, 5'b00000, 1, 0,  1, 5'd2, 1, 32'h0001_0003, 1);
        add(16'h0005, 5'b00000, 1, 0,  1, 5'd1, 1, 32'h0001_0004, 1);
        add(16'h0005, 5'b00000, 1, 0,  1, 5'd0, 0, 32'h0,         1);
        add(16'h0005, 5'b00000, 1, 0,  2, 5'd0, 0, 32'h0,         1);
        add(16'h0005, 5'b00000, 0, 0,  3, 5'd0, 0, 32'h0,         1);
        add(16'h0005, 5'b00000, 0, 1,  1, 5'd0, 0, 32'h0,         0);
        // full FIFO: the fifth push lands on the 7th edge, exactly when read_req is high
        for (int k = 1; k <= 4; k++)
            press_release(16'h0010 + 16'(k), 5'(k), 32'h0001_0011, 1'b0);
        add(16'h0015, 5'b00001, 0, 0,  6, 5'd4, 1, 32'h0001_0011, 0);
        add(16'h0015, 5'b00001, 1, 0,  1, 5'd4, 1, 32'h0001_0012, 0);
        add(16'h0015, 5'b00001, 0, 0,  3, 5'd4, 1, 32'h0001_0012, 0);
        add(16'h0015, 5'b00000, 0, 0,  8, 5'd4, 1, 32'h0001_0012, 0);
        add(16'h0015, 5'b00000, 1, 0,  1, 5'd3, 1, 32'h0001_0013, 0);
        add(16'h0015, 5'b00000, 1, 0,  1, 5'd2, 1, 32'h0001_0014, 0);
        add(16'h0015, 5'b00000, 1, 0,  1, 5'd1, 1, 32'h0001_0015, 0);
        add(16'h0015, 5'b00000, 1, 0,  1, 5'd0, 0, 32'h0,         0);
        add(16'h0015, 5'b00000, 1, 0,  2, 5'd0, 0, 32'h0,         0);
        // two entries queued ahead of the reset sequence
        press_release(16'h0021, 5'd1, 32'h0001_0021, 1'b0);
        press_release(16'h0022, 5'd2, 32'h0001_0021, 1'b0);

        #1;
        chk("async_reset_occ", 32'(buffer_occ), 32'd0);
        chk("async_reset_valid", 32'(data_valid), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;

        for (int r = 0; r < vecs.size(); r++) begin
            sw = vecs[r].sw; btn = vecs[r].btn;
            read_req = vecs[r].rd; clear_overflow = vecs[r].clr;
            repeat (vecs[r].n) @(posedge clk);
            @(negedge clk);
            chk($sformatf("row%0d_occ", r),   32'(buffer_occ), 32'(vecs[r].occ));
            chk($sformatf("row%0d_valid", r), 32'(data_valid), 32'(vecs[r].valid));
            chk($sformatf("row%0d_data", r),  read_data,       vecs[r].data);
            chk($sformatf("row%0d_ovf", r),   32'(overflow),   32'(vecs[r].ovf));
        end
        read_req = 1'b0; clear_overflow = 1'b0;

        // reset mid-debounce with two entries held, button kept high through release
        sw = 16'h0066; btn = 5'b00001;
        repeat (3) @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("midrst_occ",   32'(buffer_occ), 32'd0);
        chk("midrst_valid", 32'(data_valid), 32'd0);
        chk("midrst_data",  read_data,       32'd0);
        chk("midrst_ovf",   32'(overflow),   32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("relatch_early_occ", 32'(buffer_occ), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("relatch_occ",   32'(buffer_occ), 32'd1);
        chk("relatch_valid", 32'(data_valid), 32'd1);
        chk("relatch_data",  read_data,       32'h0001_0066);
        btn = 5'b00000;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("relatch_hold_occ", 32'(buffer_occ), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
